key_adjust_ctrl: RTL and testbench

Front-panel input stage that sits directly upstream of the sec/min/hour adjustable counters. It synchronises and debounces three raw active-low push-buttons. It produces the single-cycle key2 (increment) and key3 (decrement) pulses and the 2-bit adjust field selector that the counters compare against their own mode code. Auto-repeat while a key is held lets the user slew a field quickly.

---
 rtl/key_adjust_ctrl_pkg.sv | 20 ++
 rtl/key_adjust_ctrl_debounce.sv | 77 +++++++
 rtl/key_adjust_ctrl.sv | 158 +++++++++++++++
 tb/tb_key_adjust_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/key_adjust_ctrl_pkg.sv
// Shared definitions for the front-panel key/adjust block: field codes,
// repeat FSM state encoding and the field-advance helper.
package key_adjust_ctrl_pkg;

    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Advance the selected field, wrapping after the last one back to seconds.
    function automatic logic [1:0] next_field(input logic [1:0] cur, input logic [1:0] last);
        return (cur == last) ? FIELD_SEC : cur + 2'd1;
    endfunction

endpackage

// File: rtl/key_adjust_ctrl_debounce.sv
// key_debounce: 2-FF synchroniser, stable-level debouncer and press-event
// pulse for one raw active-low push-button.
module key_debounce #(
    parameter int unsigned DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          deb_n_q, deb_n_d;
    logic          press_q, press_d;
    logic          arm_q, arm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;

    // Debounce counter, flip on a stable level, and arming: after reset a key
    // only produces press events once it has been seen released, so a key held
    // through reset needs a release and re-press. The two released-looking
    // cycles from the synchroniser reset values stay below the arm threshold.
    always_comb begin
        deb_n_d = deb_n_q;
        cnt_d   = '0;
        press_d = 1'b0;
        arm_d   = arm_q;
        rel_d   = '0;
        if (sync2_q != deb_n_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_n_d = sync2_q;
                press_d = ~sync2_q & arm_q;
                if (sync2_q) begin
                    arm_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (!arm_q && deb_n_q && sync2_q) begin
            if (rel_q == CNT_MAX) begin
                arm_d = 1'b1;
            end else begin
                rel_d = rel_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_n_q <= 1'b1;
            press_q <= 1'b0;
            arm_q   <= 1'b0;
            cnt_q   <= '0;
            rel_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            deb_n_q <= deb_n_d;
            press_q <= press_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

    assign pressed = ~deb_n_q;
    assign press   = press_q;

endmodule

// File: rtl/key_adjust_ctrl.sv
// key_adjust_ctrl: debounces key1/key2/key3, drives the adjust field selector
// and the one-cycle inc/dec pulses. Define AUTO_REPEAT_EN to build the
// hold-to-repeat behaviour; without it each press gives exactly one pulse.
module key_adjust_ctrl
    import key_adjust_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC     = 1_000_000,
    parameter int unsigned RPT_DLY_CYC = 25_000_000,
    parameter int unsigned RPT_CYC     = 5_000_000,
    parameter int unsigned FIELD_NUM   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw17,
    input  logic       key1_n,
    input  logic       key2_n,
    input  logic       key3_n,
    output logic       key2,
    output logic       key3,
    output logic [1:0] adjust
);

    localparam logic [1:0] FIELD_LAST = 2'(FIELD_NUM - 1);

    logic       key1_press, key2_press, key3_press;
    logic       unused_key1_lvl, key2_lvl, key3_lvl;
    logic [1:0] adjust_q;
    rpt_state_e state_q, state_d;
    logic       active_q, active_d;   // 0: key2 owns the FSM, 1: key3
    logic       key2_q, key2_d, key3_q, key3_d;
    logic       act_rel, oth_pr, quit;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned TMAX = (RPT_DLY_CYC > RPT_CYC) ? RPT_DLY_CYC : RPT_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DLY_MAX = TW'(RPT_DLY_CYC - 1);
    localparam logic [TW-1:0] RPT_MAX = TW'(RPT_CYC - 1);
    logic [TW-1:0] timer_q, timer_d;
`else
    logic unused_rpt;
    assign unused_rpt = ^{RPT_DLY_CYC, RPT_CYC};
`endif

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_key1 (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key1_n),
        .pressed (unused_key1_lvl),
        .press   (key1_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_key2 (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key2_n),
        .pressed (key2_lvl),
        .press   (key2_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_key3 (
        .clk     (clk),
        .rst     (rst),
        .key_n   (key3_n),
        .pressed (key3_lvl),
        .press   (key3_press)
    );

    // Field selector: cycles on key1 presses in adjust mode, parked at seconds otherwise.
    always_ff @(posedge clk) begin
        if (rst || !sw17) begin
            adjust_q <= FIELD_SEC;
        end else if (key1_press) begin
            adjust_q <= next_field(adjust_q, FIELD_LAST);
        end
    end

    // Repeat FSM next state and pulse requests; exit conditions beat a due pulse.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        key2_d   = 1'b0;
        key3_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
        timer_d  = timer_q;
`endif
        act_rel = active_q ? ~key3_lvl : ~key2_lvl;
        oth_pr  = active_q ? key2_lvl : key3_lvl;
        quit    = ~sw17 | act_rel | oth_pr;
        case (state_q)
            ST_IDLE: begin
                if (sw17 && (key2_press ^ key3_press)) begin
                    key2_d   = key2_press;
                    key3_d   = key3_press;
                    active_d = key3_press;
                    state_d  = ST_HOLD;
`ifdef AUTO_REPEAT_EN
                    timer_d  = '0;
`endif
                end
            end
            ST_HOLD: begin
                if (quit) begin
                    state_d = ST_IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (timer_q == DLY_MAX) begin
                    key2_d  = ~active_q;
                    key3_d  = active_q;
                    timer_d = '0;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
`ifdef AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (quit) begin
                    state_d = ST_IDLE;
                end else if (timer_q == RPT_MAX) begin
                    key2_d  = ~active_q;
                    key3_d  = active_q;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            key2_q   <= 1'b0;
            key3_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            key2_q   <= key2_d;
            key3_q   <= key3_d;
`ifdef AUTO_REPEAT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    assign key2   = key2_q;
    assign key3   = key3_q;
    assign adjust = adjust_q;

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Directed bench for key_adjust_ctrl with short debounce/repeat parameters.
module tb_key_adjust_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw17 = 1'b1;
    logic       key1_n = 1'b1, key2_n = 1'b1, key3_n = 1'b1;
    logic       key2, key3;
    logic [1:0] adjust;

    int tests = 0, fails = 0;
    int cyc = 0, t0 = 0, both = 0;
    int n2, n3, first2, first3, second2, second3, last2, last3;
    int exp_adj [4] = '{1, 2, 0, 1};

    always #5 clk = ~clk;

    key_adjust_ctrl #(
        .DEB_CYC     (4),
        .RPT_DLY_CYC (20),
        .RPT_CYC     (5),
        .FIELD_NUM   (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw17   (sw17),
        .key1_n (key1_n),
        .key2_n (key2_n),
        .key3_n (key3_n),
        .key2   (key2),
        .key3   (key3),
        .adjust (adjust)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, pulses logged by cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (key2) begin
            n2++;
            if (first2 < 0) first2 = cyc;
            else if (second2 < 0) second2 = cyc;
            last2 = cyc;
        end
        if (key3) begin
            n3++;
            if (first3 < 0) first3 = cyc;
            else if (second3 < 0) second3 = cyc;
            last3 = cyc;
        end
        if (key2 && key3) both++;
    endtask

    task automatic run(input int n, input logic k1, input logic k2, input logic k3);
        key1_n = k1;
        key2_n = k2;
        key3_n = k3;
        repeat (n) step();
    endtask

    task automatic clr();
        n2 = 0; n3 = 0;
        first2 = -1; first3 = -1; second2 = -1; second3 = -1; last2 = -1; last3 = -1;
    endtask

    initial begin
        clr();
        run(2, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check_eq("rst_key2", key2, 0);
        check_eq("rst_key3", key3, 0);
        check_eq("rst_adjust", adjust, 0);
        run(10, 1'b1, 1'b1, 1'b1);

        // Bounce then a stable press of key2.
        clr();
        for (int i = 0; i < 12; i++) run(1, 1'b1, ((i / 2) % 2) != 0, 1'b1);
        t0 = cyc;
        run(10, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("bounce_cnt", n2, 1);
        check_eq("bounce_lat", first2 - t0, 7);

        // Long hold of key3.
        clr();
        t0 = cyc;
        run(60, 1'b1, 1'b1, 1'b0);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("hold3_first", first3 - t0, 7);
`ifdef AUTO_REPEAT_EN
        check_eq("hold3_cnt", n3, 9);
        check_eq("hold3_second", second3 - t0, 27);
        check_eq("hold3_last", last3 - t0, 62);
`else
        check_eq("hold3_cnt", n3, 1);
        check_eq("hold3_last", last3 - t0, 7);
`endif
        check_eq("hold3_no_key2", n2, 0);

        // Field selection.
        for (int k = 0; k < 4; k++) begin
            run(8, 1'b0, 1'b1, 1'b1);
            run(8, 1'b1, 1'b1, 1'b1);
            check_eq("adjust_seq", adjust, exp_adj[k]);
        end
        sw17 = 1'b0;
        run(1, 1'b1, 1'b1, 1'b1);
        check_eq("adjust_sw17_off", adjust, 0);
        run(8, 1'b0, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1, 1'b1);
        check_eq("adjust_key1_ignored", adjust, 0);
        sw17 = 1'b1;
        run(2, 1'b1, 1'b1, 1'b1);
        check_eq("adjust_sw17_on", adjust, 0);

        // Simultaneous inc/dec press.
        clr();
        run(30, 1'b1, 1'b0, 1'b0);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("simul_key2", n2, 0);
        check_eq("simul_key3", n3, 0);

        // key2 held, key3 pressed while repeating.
        clr();
        t0 = cyc;
        run(35, 1'b1, 1'b0, 1'b1);
        run(25, 1'b1, 1'b0, 1'b0);
        run(20, 1'b1, 1'b1, 1'b1);
`ifdef AUTO_REPEAT_EN
        check_eq("cancel_cnt", n2, 4);
        check_eq("cancel_last", last2 - t0, 37);
`else
        check_eq("cancel_cnt", n2, 1);
`endif
        check_eq("cancel_key3", n3, 0);
        clr();
        t0 = cyc;
        run(10, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("after_cancel_cnt", n2, 1);
        check_eq("after_cancel_lat", first2 - t0, 7);

        // Reset while key2 is held and repeating.
        run(8, 1'b0, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1, 1'b1);
        check_eq("adjust_pre_rst", adjust, 1);
        clr();
        run(30, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_key2", key2, 0);
        check_eq("midrst_key3", key3, 0);
        check_eq("midrst_adjust", adjust, 0);
        clr();
        run(40, 1'b1, 1'b0, 1'b1);
        check_eq("midrst_held_cnt", n2, 0);
        run(20, 1'b1, 1'b1, 1'b1);
        clr();
        t0 = cyc;
        run(10, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("repress_cnt", n2, 1);
        check_eq("repress_lat", first2 - t0, 7);

        // sw17 low during a press, then raised while still held.
        sw17 = 1'b0;
        clr();
        run(20, 1'b1, 1'b0, 1'b1);
        check_eq("sw17_off_cnt", n2, 0);
        sw17 = 1'b1;
        run(30, 1'b1, 1'b0, 1'b1);
        check_eq("sw17_raise_cnt", n2, 0);
        run(20, 1'b1, 1'b1, 1'b1);
        clr();
        run(10, 1'b1, 1'b0, 1'b1);
        run(20, 1'b1, 1'b1, 1'b1);
        check_eq("sw17_new_press", n2, 1);

        check_eq("never_both", both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
